hub75_bcm_engine: RTL and testbench

Parametrised HUB75 scan engine that replaces the separate control/colour-transmit pair with a single pipelined block. It generates frame-buffer read addresses and shifts one bit-plane per row out to the panel. It applies binary-code-modulated (BCM) output-enable timing scaled by a global brightness value, and overlaps shifting of the next plane with display of the current one. It sits between the gamma-corrected frame-buffer read path and the HUB75 pins, and supports any segment count, scan depth, colour depth and read latency.

---
 rtl/hub75_pkg.sv | 11 +
 rtl/hub75_bit_shifter.sv | 94 +++++++++
 rtl/hub75_bcm_engine.sv | 130 +++++++++++++
 tb/tb_hub75_bcm_engine.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state encodings, pixel type and BCM on-time helper
package hub75_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_LATCH} shift_state_e;
  typedef enum logic [1:0] {D_OFF, D_ON, D_DONE} disp_state_e;
  localparam int pixel_bpp_c = 8;
  typedef logic [2:0][pixel_bpp_c-1:0] pixel_t;
  // plane b stays lit for (brightness+1) << b clk cycles
  function automatic logic [31:0] on_time(input logic [4:0] b, input logic [7:0] brightness);
    return ({24'd0, brightness} + 32'd1) << b;
  endfunction
endpackage

// File: rtl/hub75_bit_shifter.sv
// hub75_bit_shifter: shifts one bit-plane of a row out on O_CLK with read-latency compensation
module hub75_bit_shifter #(
  parameter int hpixel_p = 64,
  parameter int bpp_p = 8,
  parameter int segments_p = 2,
  parameter int rd_lat_p = 2,
  parameter int addr_w_p = 12,
  parameter int pl_w_p = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic [3:0]                     i_clk_div,
  input  logic [addr_w_p-1:0]            i_base,
  input  logic [pl_w_p-1:0]              i_plane,
  input  logic [segments_p*3*bpp_p-1:0]  i_rd_data,
  output logic                           o_done,
  output logic [addr_w_p-1:0]            o_rd_addr,
  output logic                           o_sclk,
  output logic [segments_p*3-1:0]        o_rgb
);
  localparam int col_w_p = $clog2(hpixel_p);
  localparam logic [col_w_p-1:0] col_last_c = col_w_p'(hpixel_p - 1);
  localparam logic [3:0] lat_c = 4'(rd_lat_p);
  logic busy_q, busy_d, sclk_q, sclk_d, last, issue;
  logic [col_w_p-1:0] col_q, col_d;
  logic [4:0] cyc_q, cyc_d;
  logic [3:0] div_q, div_d;
  logic [pl_w_p-1:0] plane_q, plane_d;
  logic [addr_w_p-1:0] addr_q, addr_d;
  logic [segments_p*3-1:0] rgb_q, rgb_d, bits;
  logic [rd_lat_p-1:0] vld_q, vld_d;
  logic [rd_lat_p:0] vld;
  // period sequencing: address on cycle 0, data captured when the read returns, O_CLK high in the second half
  always_comb begin
    last = busy_q && cyc_q == {div_q, 1'b1};
    issue = busy_q && cyc_q == 5'd0;
    vld = {vld_q, issue};
    vld_d = vld[rd_lat_p-1:0];
    bits = '0;
    for (int i = 0; i < segments_p * 3; i++) bits[i] = i_rd_data[i * bpp_p + int'(plane_q)];
    rgb_d = vld[rd_lat_p] ? bits : rgb_q;
    o_done = last && col_q == col_last_c;
    busy_d = busy_q;
    col_d = col_q;
    cyc_d = cyc_q;
    div_d = div_q;
    plane_d = plane_q;
    addr_d = addr_q;
    sclk_d = sclk_q;
    if (i_start) begin
      busy_d = 1'b1;
      col_d = '0;
      cyc_d = '0;
      div_d = i_clk_div < lat_c ? lat_c : i_clk_div;
      plane_d = i_plane;
      addr_d = i_base;
      sclk_d = 1'b0;
    end else if (busy_q) begin
      cyc_d = last ? 5'd0 : cyc_q + 5'd1;
      sclk_d = cyc_q == {1'b0, div_q} ? 1'b1 : last ? 1'b0 : sclk_q;
      col_d = last ? col_q + col_w_p'(1) : col_q;
      addr_d = last && !o_done ? addr_q + addr_w_p'(1) : addr_q;
      busy_d = !o_done;
    end
  end
  // shifter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      col_q <= '0;
      cyc_q <= '0;
      div_q <= '0;
      plane_q <= '0;
      addr_q <= '0;
      rgb_q <= '0;
      vld_q <= '0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      col_q <= col_d;
      cyc_q <= cyc_d;
      div_q <= div_d;
      plane_q <= plane_d;
      addr_q <= addr_d;
      rgb_q <= rgb_d;
      vld_q <= vld_d;
    end
  end
  assign o_rd_addr = addr_q;
  assign o_sclk = sclk_q;
  assign o_rgb = rgb_q;
endmodule

// File: rtl/hub75_bcm_engine.sv
// hub75_bcm_engine: HUB75 row/plane scanner with BCM output-enable timing overlapping the next shift
module hub75_bcm_engine
  import hub75_pkg::*;
#(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p = 8,
  parameter int segments_p = 2,
  parameter int rd_lat_p = 2,
  localparam int rows_p = vpixel_p / segments_p,
  localparam int row_w_p = $clog2(rows_p),
  localparam int addr_w_p = $clog2(hpixel_p * vpixel_p)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_enable,
  input  logic [3:0]                    i_clk_div,
  input  logic [7:0]                    i_brightness,
  output logic [addr_w_p-1:0]           o_rd_addr,
  input  logic [segments_p*3*bpp_p-1:0] i_rd_data,
  output logic                          O_CLK,
  output logic                          STB,
  output logic                          OE,
  output logic [row_w_p-1:0]            o_row,
  output logic [segments_p*3-1:0]       o_rgb,
  output logic                          o_frame_start
);
  localparam int pl_w_p = bpp_p > 1 ? $clog2(bpp_p) : 1;
  localparam int ot_w_p = bpp_p + 9;
  localparam logic [pl_w_p-1:0] pl_last_c = pl_w_p'(bpp_p - 1);
  localparam logic [row_w_p-1:0] row_last_c = row_w_p'(rows_p - 1);
  shift_state_e state_q, state_d;
  disp_state_e disp_q, disp_d;
  logic [1:0] lat_q, lat_d;
  logic [row_w_p-1:0] row_q, row_d, orow_q, orow_d;
  logic [pl_w_p-1:0] plane_q, plane_d;
  logic [ot_w_p-1:0] ot_q, ot_d;
  logic stb_q, stb_d, oe_q, oe_d, fs_q, fs_d, start, sh_done;
  logic [addr_w_p-1:0] base;
  assign base = addr_w_p'(int'(row_d) * hpixel_p);
  hub75_bit_shifter #(
    .hpixel_p(hpixel_p), .bpp_p(bpp_p), .segments_p(segments_p),
    .rd_lat_p(rd_lat_p), .addr_w_p(addr_w_p), .pl_w_p(pl_w_p)
  ) u_shifter (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_clk_div(i_clk_div),
    .i_base(base), .i_plane(plane_d), .i_rd_data(i_rd_data), .o_done(sh_done),
    .o_rd_addr(o_rd_addr), .o_sclk(O_CLK), .o_rgb(o_rgb)
  );
  // shifter and display FSMs; the latch hands the shifted plane to the display and starts the next shift
  always_comb begin
    state_d = state_q;
    disp_d = disp_q;
    lat_d = lat_q;
    row_d = row_q;
    plane_d = plane_q;
    ot_d = ot_q;
    orow_d = orow_q;
    fs_d = 1'b0;
    start = 1'b0;
    if (disp_q == D_ON) begin
      ot_d = ot_q - ot_w_p'(1);
      disp_d = ot_q == ot_w_p'(1) ? D_DONE : D_ON;
    end
    case (state_q)
      S_IDLE: if (i_enable) begin
        state_d = S_SHIFT;
        start = 1'b1;
      end
      S_SHIFT: if (sh_done) state_d = S_WAIT;
      S_WAIT: if (disp_q != D_ON) begin
        if (!i_enable) begin
          state_d = S_IDLE;
          disp_d = D_OFF;
          row_d = '0;
          plane_d = '0;
        end else begin
          state_d = S_LATCH;
          lat_d = 2'd0;
        end
      end
      S_LATCH: begin
        lat_d = lat_q + 2'd1;
        if (lat_q == 2'd0) begin
          orow_d = row_q;
          fs_d = row_q == '0 && plane_q == '0;
        end
        if (lat_q == 2'd2) begin
          state_d = S_SHIFT;
          start = 1'b1;
          disp_d = D_ON;
          ot_d = ot_w_p'(on_time(5'(plane_q), i_brightness));
          plane_d = plane_q == pl_last_c ? '0 : plane_q + pl_w_p'(1);
          row_d = plane_q != pl_last_c ? row_q : row_q == row_last_c ? '0 : row_q + row_w_p'(1);
        end
      end
    endcase
    stb_d = state_d == S_LATCH && lat_d != 2'd0;
    oe_d = disp_d != D_ON;
  end
  // control state and registered panel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      disp_q <= D_OFF;
      lat_q <= '0;
      row_q <= '0;
      plane_q <= '0;
      ot_q <= '0;
      orow_q <= '0;
      stb_q <= 1'b0;
      oe_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q <= disp_d;
      lat_q <= lat_d;
      row_q <= row_d;
      plane_q <= plane_d;
      ot_q <= ot_d;
      orow_q <= orow_d;
      stb_q <= stb_d;
      oe_q <= oe_d;
      fs_q <= fs_d;
    end
  end
  assign STB = stb_q;
  assign OE = oe_q;
  assign o_row = orow_q;
  assign o_frame_start = fs_q;
endmodule

// File: tb/tb_hub75_bcm_engine.sv
// tb_hub75_bcm_engine: directed checks of shift timing, BCM on-times, scan order, disable and async reset
`timescale 1ns/1ps
module tb_hub75_bcm_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_enable = 1'b0;
  logic [3:0] i_clk_div = 4'd3;
  logic [7:0] i_brightness = 8'd0;
  logic [4:0] o_rd_addr;
  logic [11:0] i_rd_data, p0 = '0, p1 = '0;
  logic O_CLK, STB, OE, o_frame_start;
  logic [0:0] o_row;
  logic [5:0] o_rgb;
  int checks = 0, errors = 0, oe_run = 0, fs_cnt = 0;
  int rise_cyc[$], rise_addr[$], rise_rgb[$], stb_row[$], stb_fs[$], stb_rises[$], oe_len[$];
  int cyc = 0;
  logic prev_clk = 1'b0, prev_stb = 1'b0;
  int exp_row[8] = '{0, 0, 1, 1, 0, 0, 0, 1};
  int exp_fs[8] = '{1, 0, 0, 0, 1, 1, 0, 0};
  int exp_oe[7] = '{1, 512, 1, 2, 1, 256, 512};

  hub75_bcm_engine #(
    .hpixel_p(8), .vpixel_p(4), .bpp_p(2), .segments_p(2), .rd_lat_p(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_clk_div(i_clk_div),
    .i_brightness(i_brightness), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .O_CLK(O_CLK), .STB(STB), .OE(OE), .o_row(o_row), .o_rgb(o_rgb),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p0 <= 12'(o_rd_addr);
    p1 <= p0;
  end
  assign i_rd_data = p1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_rgb(input int a, input int p);
    logic [11:0] d;
    int r;
    d = 12'(a);
    r = 0;
    for (int i = 0; i < 6; i++) if (d[i * 2 + p]) r |= 1 << i;
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (O_CLK && !prev_clk) begin
        rise_cyc.push_back(cyc);
        rise_addr.push_back(int'(o_rd_addr));
        rise_rgb.push_back(int'(o_rgb));
      end
      if (STB) check("oe_at_stb", 32'(OE), 32'd1);
      if (STB && !prev_stb) begin
        stb_row.push_back(int'(o_row));
        stb_fs.push_back(int'(o_frame_start));
        stb_rises.push_back(rise_cyc.size());
      end
      if (o_frame_start) fs_cnt++;
      if (!OE) oe_run++;
      else if (oe_run > 0) begin
        oe_len.push_back(oe_run);
        oe_run = 0;
      end
    end
    prev_clk = O_CLK;
    prev_stb = STB;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_stb(input int n);
    int t;
    t = 0;
    while (stb_row.size() < n && t < 3000) begin
      tick();
      t++;
    end
    check("stb_reached", 32'(stb_row.size() >= n), 32'd1);
  endtask

  initial begin
    int base, n, k, row, pl;
    repeat (3) tick();
    check("rst_oclk", 32'(O_CLK), 32'd0);
    check("rst_stb", 32'(STB), 32'd0);
    check("rst_oe", 32'(OE), 32'd1);
    check("rst_row", 32'(o_row), 32'd0);
    check("rst_rgb", 32'(o_rgb), 32'd0);
    check("rst_addr", 32'(o_rd_addr), 32'd0);
    check("rst_fs", 32'(o_frame_start), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_no_rise", 32'(rise_cyc.size()), 32'd0);
    i_enable = 1'b1;
    wait_stb(1);
    repeat (4) tick();
    i_brightness = 8'd255;
    wait_stb(2);
    i_clk_div = 4'd0;
    repeat (4) tick();
    i_brightness = 8'd0;
    wait_stb(5);
    repeat (10) tick();
    i_enable = 1'b0;
    repeat (150) tick();
    check("dis_stb_count", 32'(stb_row.size()), 32'd5);
    check("dis_rises", 32'(rise_cyc.size()), 32'd48);
    check("dis_oe", 32'(OE), 32'd1);
    check("dis_oclk", 32'(O_CLK), 32'd0);
    check("dis_stb", 32'(STB), 32'd0);
    i_brightness = 8'd255;
    i_enable = 1'b1;
    wait_stb(6);
    wait_stb(8);
    repeat (20) tick();
    check("pre_rst_oe", 32'(OE), 32'd0);
    check("pre_rst_row", 32'(o_row), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_oe", 32'(OE), 32'd1);
    check("arst_oclk", 32'(O_CLK), 32'd0);
    check("arst_row", 32'(o_row), 32'd0);
    check("arst_stb", 32'(STB), 32'd0);
    check("stb_log_size", 32'(stb_row.size()), 32'd8);
    for (int i = 0; i < 8 && i < stb_row.size(); i++) begin
      check($sformatf("latch%0d_row", i), 32'(stb_row[i]), 32'(exp_row[i]));
      check($sformatf("latch%0d_fs", i), 32'(stb_fs[i]), 32'(exp_fs[i]));
      check($sformatf("latch%0d_rises", i), 32'(stb_rises[i]), 32'(i < 5 ? 8 * (i + 1) : 8 * (i - 4) + 48));
    end
    check("fs_pulses", 32'(fs_cnt), 32'd3);
    check("oe_log_size", 32'(oe_len.size() >= 7), 32'd1);
    for (int i = 0; i < 7 && i < oe_len.size(); i++)
      check($sformatf("oe_len%0d", i), 32'(oe_len[i]), 32'(exp_oe[i]));
    check("rise_log_size", 32'(rise_cyc.size() > 64), 32'd1);
    for (int j = 0; j < rise_cyc.size(); j++) begin
      base = j < 48 ? 0 : 48;
      n = (j - base) / 8;
      k = (j - base) % 8;
      row = (n / 2) % 2;
      pl = n % 2;
      check($sformatf("rise%0d_addr", j), 32'(rise_addr[j]), 32'(row * 8 + k));
      check($sformatf("rise%0d_rgb", j), 32'(rise_rgb[j]), 32'(exp_rgb(row * 8 + k, pl)));
      if (k > 0) check($sformatf("rise%0d_period", j), 32'(rise_cyc[j] - rise_cyc[j-1]), 32'(j < 16 ? 8 : 6));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
